// File: rtl/uart_slave.sv
// uart_slave: memory-mapped 8N1 UART on the picorv32 native bus.
//
// Registers (addr[3:2]):
//   0 DATA    W: push byte into TX FIFO   R: received byte (pops it) or 0
//   1 STATUS  R: {count[11:8], frame_err, rx_overrun, rx_valid,
//                 tx_busy, tx_empty, tx_full}   W: W1C on bits 5:4
//   2 DIVISOR R/W bits[15:0], byte lanes wstrb[1:0], minimum 4
//   3 reserved
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   uart_sel              bus select, held until uart_ready
//   wstrb, addr           byte enables (0 = read), byte address
//   uart_data_i           write data
//   uart_ready            one-cycle completion pulse
//   uart_data_o           read data, valid while uart_ready=1
//   tx, rx                serial line out / in (rx is asynchronous)
module uart_slave #(
    parameter int DEFAULT_DIV = 234,
    parameter int TX_DEPTH    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_sel,
    input  logic [3:0]  wstrb,
    input  logic [3:0]  addr,
    input  logic [31:0] uart_data_i,
    output logic        uart_ready,
    output logic [31:0] uart_data_o,
    output logic        tx,
    input  logic        rx
);

    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;

    // ---------------------------------------------------------------
    // Bus handshake. The request is captured on the cycle sel is seen;
    // the following cycle is the ready cycle, and every register side
    // effect is applied on the clock edge that ends it. The cycle after
    // ready is ignored because the bus may still be dropping sel.
    // ---------------------------------------------------------------
    logic        ready_reg;
    logic        ready_prev_reg;
    logic [1:0]  addr_reg;
    logic [3:0]  wstrb_reg;
    logic [15:0] wdata_reg;
    logic        accept;

    assign accept = uart_sel && !ready_reg && !ready_prev_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_reg      <= 1'b0;
            ready_prev_reg <= 1'b0;
            addr_reg       <= 2'd0;
            wstrb_reg      <= 4'd0;
            wdata_reg      <= 16'd0;
        end else begin
            ready_reg      <= accept;
            ready_prev_reg <= ready_reg;
            if (accept) begin
                addr_reg  <= addr[3:2];
                wstrb_reg <= wstrb;
                wdata_reg <= uart_data_i[15:0];
            end
        end
    end

    logic wr_en, rd_en;
    logic data_push, rx_pop, status_w1c, div_wr;

    assign wr_en      = ready_reg && (wstrb_reg != 4'd0);
    assign rd_en      = ready_reg && (wstrb_reg == 4'd0);
    assign data_push  = wr_en && (addr_reg == 2'd0) && wstrb_reg[0];
    assign status_w1c = wr_en && (addr_reg == 2'd1) && wstrb_reg[0];
    assign div_wr     = wr_en && (addr_reg == 2'd2) && (wstrb_reg[1:0] != 2'b00);

    // ---------------------------------------------------------------
    // Divisor register
    // ---------------------------------------------------------------
    logic [15:0] div_reg;
    logic [15:0] div_wr_val;

    always_comb begin
        div_wr_val = {wstrb_reg[1] ? wdata_reg[15:8] : div_reg[15:8],
                      wstrb_reg[0] ? wdata_reg[7:0]  : div_reg[7:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg <= 16'(DEFAULT_DIV);
        end else if (div_wr) begin
            div_reg <= (div_wr_val < 16'd4) ? 16'd4 : div_wr_val;
        end
    end

    // ---------------------------------------------------------------
    // TX FIFO
    // ---------------------------------------------------------------
    logic [7:0]    fifo_mem [TX_DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] tx_count_reg;
    logic          tx_full, tx_empty, tx_pop, push_ok;

    assign tx_full  = (tx_count_reg == CW'(TX_DEPTH));
    assign tx_empty = (tx_count_reg == '0);
    // A full FIFO still takes the byte if the shifter pops in the same cycle.
    assign push_ok  = data_push && (!tx_full || tx_pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= wdata_reg[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            tx_count_reg <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (tx_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push_ok, tx_pop})
                2'b10:   tx_count_reg <= tx_count_reg + CW'(1);
                2'b01:   tx_count_reg <= tx_count_reg - CW'(1);
                default: tx_count_reg <= tx_count_reg;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // TX shifter
    // ---------------------------------------------------------------
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t   tx_state_reg, tx_state_next;
    logic [15:0] tx_cnt_reg, tx_cnt_next;
    logic [15:0] tx_div_reg, tx_div_next;
    logic [2:0]  tx_bit_reg, tx_bit_next;
    logic [7:0]  tx_shift_reg, tx_shift_next;
    logic        tx_reg, tx_next;
    logic        tx_bit_done;

    assign tx_bit_done = (tx_cnt_reg == tx_div_reg - 16'd1);

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg + 16'd1;
        tx_div_next   = tx_div_reg;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        tx_next       = tx_reg;
        tx_pop        = 1'b0;
        case (tx_state_reg)
            TX_IDLE: begin
                tx_next     = 1'b1;
                tx_cnt_next = 16'd0;
                tx_pop      = !tx_empty;
            end
            TX_START: begin
                if (tx_bit_done) begin
                    tx_state_next = TX_DATA;
                    tx_cnt_next   = 16'd0;
                    tx_bit_next   = 3'd0;
                    tx_next       = tx_shift_reg[0];
                end
            end
            TX_DATA: begin
                if (tx_bit_done) begin
                    tx_cnt_next = 16'd0;
                    if (tx_bit_reg == 3'd7) begin
                        tx_state_next = TX_STOP;
                        tx_next       = 1'b1;
                    end else begin
                        tx_bit_next   = tx_bit_reg + 3'd1;
                        tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                        tx_next       = tx_shift_reg[1];
                    end
                end
            end
            TX_STOP: begin
                if (tx_bit_done) begin
                    tx_state_next = TX_IDLE;
                    tx_cnt_next   = 16'd0;
                    // Chain straight into the next frame: no idle gap.
                    tx_pop        = !tx_empty;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
        if (tx_pop) begin
            tx_state_next = TX_START;
            tx_cnt_next   = 16'd0;
            tx_bit_next   = 3'd0;
            tx_shift_next = fifo_mem[rd_ptr_reg];
            // Divisor is frozen per frame; later writes affect later frames.
            tx_div_next   = div_reg;
            tx_next       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_reg <= TX_IDLE;
            tx_cnt_reg   <= 16'd0;
            tx_div_reg   <= 16'(DEFAULT_DIV);
            tx_bit_reg   <= 3'd0;
            tx_shift_reg <= 8'd0;
            tx_reg       <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_div_reg   <= tx_div_next;
            tx_bit_reg   <= tx_bit_next;
            tx_shift_reg <= tx_shift_next;
            tx_reg       <= tx_next;
        end
    end

    assign tx = tx_reg;

    // ---------------------------------------------------------------
    // RX deserializer
    // ---------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic        rx_s1_reg, rx_s2_reg, rx_prev_reg;
    rx_state_t   rx_state_reg, rx_state_next;
    logic [15:0] rx_cnt_reg, rx_cnt_next;
    logic [15:0] rx_div_reg, rx_div_next;
    logic [2:0]  rx_bit_reg, rx_bit_next;
    logic [7:0]  rx_shift_reg, rx_shift_next;
    logic        rx_load;
    logic        rx_half_done, rx_bit_done;

    assign rx_half_done = (rx_cnt_reg == (rx_div_reg >> 1) - 16'd1);
    assign rx_bit_done  = (rx_cnt_reg == rx_div_reg - 16'd1);

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg + 16'd1;
        rx_div_next   = rx_div_reg;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_load       = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                rx_cnt_next = 16'd0;
                if (rx_prev_reg && !rx_s2_reg) begin
                    rx_state_next = RX_START;
                    rx_div_next   = div_reg;
                end
            end
            RX_START: begin
                if (rx_half_done) begin
                    rx_cnt_next   = 16'd0;
                    rx_bit_next   = 3'd0;
                    // Line back high at mid start bit: a glitch, not a frame.
                    rx_state_next = rx_s2_reg ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_bit_done) begin
                    rx_cnt_next   = 16'd0;
                    rx_shift_next = {rx_s2_reg, rx_shift_reg[7:1]};
                    if (rx_bit_reg == 3'd7) begin
                        rx_state_next = RX_STOP;
                    end else begin
                        rx_bit_next = rx_bit_reg + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (rx_bit_done) begin
                    rx_cnt_next   = 16'd0;
                    rx_load       = 1'b1;
                    rx_state_next = RX_IDLE;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1_reg    <= 1'b1;
            rx_s2_reg    <= 1'b1;
            rx_prev_reg  <= 1'b1;
            rx_state_reg <= RX_IDLE;
            rx_cnt_reg   <= 16'd0;
            rx_div_reg   <= 16'(DEFAULT_DIV);
            rx_bit_reg   <= 3'd0;
            rx_shift_reg <= 8'd0;
        end else begin
            rx_s1_reg    <= rx;
            rx_s2_reg    <= rx_s1_reg;
            rx_prev_reg  <= rx_s2_reg;
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_div_reg   <= rx_div_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shift_reg <= rx_shift_next;
        end
    end

    // RX holding register and sticky flags. A hardware set always beats
    // a same-cycle software clear or pop.
    logic [7:0] rx_byte_reg;
    logic       rx_valid_reg, rx_overrun_reg, frame_err_reg;

    assign rx_pop = rd_en && (addr_reg == 2'd0) && rx_valid_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_byte_reg    <= 8'd0;
            rx_valid_reg   <= 1'b0;
            rx_overrun_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            if (rx_load) begin
                rx_byte_reg  <= rx_shift_reg;
                rx_valid_reg <= 1'b1;
            end else if (rx_pop) begin
                rx_valid_reg <= 1'b0;
            end

            if (rx_load && rx_valid_reg && !rx_pop) begin
                rx_overrun_reg <= 1'b1;
            end else if (status_w1c && wdata_reg[4]) begin
                rx_overrun_reg <= 1'b0;
            end

            if (rx_load && !rx_s2_reg) begin
                frame_err_reg <= 1'b1;
            end else if (status_w1c && wdata_reg[5]) begin
                frame_err_reg <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------
    // Read mux. Driven from live state during the ready cycle so that
    // the value returned matches the pop applied at the end of it.
    // ---------------------------------------------------------------
    logic        tx_busy;
    logic [4:0]  count_ext;
    logic [31:0] rd_data;

    assign tx_busy   = !tx_empty || (tx_state_reg != TX_IDLE);
    assign count_ext = 5'(tx_count_reg);

    always_comb begin
        rd_data = 32'd0;
        case (addr_reg)
            2'd0: if (rx_valid_reg) rd_data = {24'd0, rx_byte_reg};
            2'd1: rd_data = {20'd0, count_ext[3:0], 2'b00, frame_err_reg,
                             rx_overrun_reg, rx_valid_reg, tx_busy, tx_empty, tx_full};
            2'd2: rd_data = {16'd0, div_reg};
            default: rd_data = 32'd0;
        endcase
    end

    assign uart_ready  = ready_reg;
    assign uart_data_o = ready_reg ? rd_data : 32'd0;

    logic unused_bits;
    assign unused_bits = ^{uart_data_i[31:16], addr[1:0], count_ext[4]};

endmodule
